// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control unit: opcodes, ALU operation
// codes, IR field positions and the sequencer state encoding.
package cpu_ctrl_pkg;

   localparam int OPC_LSB = 27;
   localparam int RA_LSB  = 23;
   localparam int RB_LSB  = 19;
   localparam int RC_LSB  = 15;
   localparam int OPC_W   = 5;
   localparam int RIDX_W  = 4;

   localparam logic [OPC_W-1:0] OPC_ADD = 5'b00011;
   localparam logic [OPC_W-1:0] OPC_SUB = 5'b00100;
   localparam logic [OPC_W-1:0] OPC_AND = 5'b00101;
   localparam logic [OPC_W-1:0] OPC_OR  = 5'b00110;
   localparam logic [OPC_W-1:0] OPC_MUL = 5'b01111;
   localparam logic [OPC_W-1:0] OPC_DIV = 5'b10000;
   localparam logic [OPC_W-1:0] OPC_NEG = 5'b10001;
   localparam logic [OPC_W-1:0] OPC_NOT = 5'b10010;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;
   localparam logic [4:0] ALU_NEG = 5'b01000;
   localparam logic [4:0] ALU_NOT = 5'b01001;

   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7,
      ST_HALT = 4'd8
   } state_e;

   typedef enum logic [1:0] {
      CLS_ALU3,
      CLS_MULDIV,
      CLS_UNARY,
      CLS_ILLEGAL
   } instr_cls_e;

   function automatic instr_cls_e classify(input logic [OPC_W-1:0] opc);
      case (opc)
         OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: classify = CLS_ALU3;
         OPC_MUL, OPC_DIV:                  classify = CLS_MULDIV;
         OPC_NEG, OPC_NOT:                  classify = CLS_UNARY;
         default:                           classify = CLS_ILLEGAL;
      endcase
   endfunction

   function automatic logic [4:0] alu_op(input logic [OPC_W-1:0] opc);
      case (opc)
         OPC_SUB: alu_op = ALU_SUB;
         OPC_AND: alu_op = ALU_AND;
         OPC_OR:  alu_op = ALU_OR;
         OPC_MUL: alu_op = ALU_MUL;
         OPC_DIV: alu_op = ALU_DIV;
         OPC_NEG: alu_op = ALU_NEG;
         OPC_NOT: alu_op = ALU_NOT;
         default: alu_op = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Converts a 4-bit register index into an NREG-wide one-hot enable; all
// zeros when en is low or the index is beyond NREG.
module reg_select_decoder
   import cpu_ctrl_pkg::*;
#(
   parameter int NREG = 16
) (
   input  logic [RIDX_W-1:0] idx,
   input  logic              en,
   output logic [NREG-1:0]   onehot
);

   for (genvar g = 0; g < NREG; g++) begin : g_bit
      assign onehot[g] = en && (int'(idx) == g);
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving datapath strobes from state and IR.
// Define CU_INSTR_COUNT_EN to build the retired-instruction counter.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int NREG  = 16,
   parameter int CNT_W = 32
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic [31:0]      IR,
   input  logic             Stop,
   output logic             PCout,
   output logic             MDRout,
   output logic             ZLowout,
   output logic             ZHighout,
   output logic             MARin,
   output logic             MDRin,
   output logic             IRin,
   output logic             PCin,
   output logic             Yin,
   output logic             ZLowin,
   output logic             ZHighin,
   output logic             LOin,
   output logic             HIin,
   output logic             IncPC,
   output logic             Read,
   output logic [4:0]       OP,
   output logic [NREG-1:0]  Rin,
   output logic [NREG-1:0]  Rout,
   output logic             Run,
   output logic             Illegal,
   output logic [CNT_W-1:0] InstrCount,
   output state_e           state_dbg
);

   state_e            state_q, state_d;
   instr_cls_e        cls;
   logic [OPC_W-1:0]  opcode;
   logic [RIDX_W-1:0] ra, rb, rc, rout_idx;
   logic              rin_en, rout_en, last_exec;
   logic              illegal_q;
   logic              unused_ir_bits;

   assign opcode         = IR[OPC_LSB +: OPC_W];
   assign ra             = IR[RA_LSB +: RIDX_W];
   assign rb             = IR[RB_LSB +: RIDX_W];
   assign rc             = IR[RC_LSB +: RIDX_W];
   assign unused_ir_bits = ^IR[RC_LSB-1:0];
   assign cls            = classify(opcode);
   assign state_dbg      = state_q;
   assign Illegal        = illegal_q;

   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q   <= ST_RST;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_T3 && cls == CLS_ILLEGAL)
            illegal_q <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_exec = 1'b0;
      PCout = 1'b0; MDRout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0;
      MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; PCin = 1'b0; Yin = 1'b0;
      ZLowin = 1'b0; ZHighin = 1'b0; LOin = 1'b0; HIin = 1'b0;
      IncPC = 1'b0; Read = 1'b0;
      OP       = 5'b00000;
      rin_en   = 1'b0;
      rout_en  = 1'b0;
      rout_idx = rb;
      Run      = (state_q != ST_RST) && (state_q != ST_HALT);
      case (state_q)
         ST_RST: state_d = ST_T0;
         ST_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowin = 1'b1; ZHighin = 1'b1;
            state_d = ST_T1;
         end
         ST_T1: begin
            ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            state_d = ST_T2;
         end
         ST_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
            state_d = ST_T3;
         end
         ST_T3: begin
            case (cls)
               CLS_ALU3:   begin rout_en = 1'b1; Yin = 1'b1; end
               CLS_MULDIV: begin rout_en = 1'b1; rout_idx = ra; Yin = 1'b1; end
               CLS_UNARY: begin
                  rout_en = 1'b1; OP = alu_op(opcode); ZLowin = 1'b1; ZHighin = 1'b1;
               end
               default: ;
            endcase
            state_d = (cls == CLS_ILLEGAL) ? ST_HALT : ST_T4;
         end
         ST_T4: begin
            if (cls == CLS_UNARY) begin
               ZLowout = 1'b1; rin_en = 1'b1; last_exec = 1'b1;
            end else begin
               rout_en  = 1'b1;
               rout_idx = (cls == CLS_MULDIV) ? rb : rc;
               OP = alu_op(opcode); ZLowin = 1'b1; ZHighin = 1'b1;
               state_d = ST_T5;
            end
         end
         ST_T5: begin
            ZLowout = 1'b1;
            if (cls == CLS_ALU3) begin
               rin_en = 1'b1; last_exec = 1'b1;
            end else begin
               LOin = 1'b1;
               state_d = ST_T6;
            end
         end
         ST_T6: begin
            ZHighout = 1'b1; HIin = 1'b1; last_exec = 1'b1;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RST;
      endcase
      // Stop only takes effect at an instruction boundary.
      if (last_exec)
         state_d = Stop ? ST_HALT : ST_T0;
   end

   reg_select_decoder #(.NREG(NREG)) u_rin_dec (
      .idx    (ra),
      .en     (rin_en),
      .onehot (Rin)
   );

   reg_select_decoder #(.NREG(NREG)) u_rout_dec (
      .idx    (rout_idx),
      .en     (rout_en),
      .onehot (Rout)
   );

`ifdef CU_INSTR_COUNT_EN
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge Clock) begin
      if (Clear)
         count_q <= '0;
      else if (last_exec)
         count_q <= count_q + CNT_W'(1);
   end

   assign InstrCount = count_q;
`else
   assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute strobe sequences,
// illegal-opcode halt, mid-instruction Clear and Stop at an instruction boundary.
module tb_control_sequencer;
   import cpu_ctrl_pkg::*;

   localparam int NREG  = 16;
   localparam int CNT_W = 32;

   localparam logic [31:0] IR_MUL = 32'h7B38_0000;
   localparam logic [31:0] IR_ADD = 32'h191A_0000;
   localparam logic [31:0] IR_NEG = 32'h8A88_0000;
   localparam logic [31:0] IR_ILL = 32'hF800_0000;

   localparam logic [14:0] S_PCOUT    = 15'h4000;
   localparam logic [14:0] S_MDROUT   = 15'h2000;
   localparam logic [14:0] S_ZLOWOUT  = 15'h1000;
   localparam logic [14:0] S_ZHIGHOUT = 15'h0800;
   localparam logic [14:0] S_MARIN    = 15'h0400;
   localparam logic [14:0] S_MDRIN    = 15'h0200;
   localparam logic [14:0] S_IRIN     = 15'h0100;
   localparam logic [14:0] S_PCIN     = 15'h0080;
   localparam logic [14:0] S_YIN      = 15'h0040;
   localparam logic [14:0] S_ZLOWIN   = 15'h0020;
   localparam logic [14:0] S_ZHIGHIN  = 15'h0010;
   localparam logic [14:0] S_LOIN     = 15'h0008;
   localparam logic [14:0] S_HIIN     = 15'h0004;
   localparam logic [14:0] S_INCPC    = 15'h0002;
   localparam logic [14:0] S_READ     = 15'h0001;

`ifdef CU_INSTR_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic             Clock = 1'b0;
   logic             Clear, Stop;
   logic [31:0]      IR;
   logic             PCout, MDRout, ZLowout, ZHighout;
   logic             MARin, MDRin, IRin, PCin, Yin, ZLowin, ZHighin, LOin, HIin;
   logic             IncPC, Read, Run, Illegal;
   logic [4:0]       OP;
   logic [NREG-1:0]  Rin, Rout;
   logic [CNT_W-1:0] InstrCount;
   state_e           state_dbg;
   logic [14:0]      strobes;

   int num_checks = 0;
   int num_errors = 0;

   control_sequencer #(.NREG(NREG), .CNT_W(CNT_W)) dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
      .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout), .ZHighout(ZHighout),
      .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .PCin(PCin), .Yin(Yin),
      .ZLowin(ZLowin), .ZHighin(ZHighin), .LOin(LOin), .HIin(HIin),
      .IncPC(IncPC), .Read(Read), .OP(OP), .Rin(Rin), .Rout(Rout),
      .Run(Run), .Illegal(Illegal), .InstrCount(InstrCount), .state_dbg(state_dbg)
   );

   // clock / reset block
   always #5 Clock = ~Clock;

   assign strobes = {PCout, MDRout, ZLowout, ZHighout, MARin, MDRin, IRin, PCin,
                     Yin, ZLowin, ZHighin, LOin, HIin, IncPC, Read};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_count(input int n);
      return CNT_ON ? 32'(n) : 32'd0;
   endfunction

   // Checks all outputs of the current cycle (called mid-cycle, at negedge).
   task automatic check_out(input string tag, input state_e st, input logic [14:0] str,
                            input logic [4:0] op, input logic [15:0] rin,
                            input logic [15:0] rout);
      check({tag, ".state"},   32'(state_dbg), 32'(st));
      check({tag, ".strobes"}, 32'(strobes),   32'(str));
      check({tag, ".op"},      32'(OP),        32'(op));
      check({tag, ".rin"},     32'(Rin),       32'(rin));
      check({tag, ".rout"},    32'(Rout),      32'(rout));
      check({tag, ".run"},     32'(Run),       32'((st != ST_RST) && (st != ST_HALT)));
   endtask

   task automatic step(input string tag, input state_e st, input logic [14:0] str,
                       input logic [4:0] op, input logic [15:0] rin,
                       input logic [15:0] rout);
      check_out(tag, st, str, op, rin, rout);
      @(negedge Clock);
   endtask

   task automatic fetch(input string tag);
      step({tag, ".t0"}, ST_T0, S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN | S_ZHIGHIN, 5'd0, 16'h0, 16'h0);
      step({tag, ".t1"}, ST_T1, S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 5'd0, 16'h0, 16'h0);
      step({tag, ".t2"}, ST_T2, S_MDROUT | S_IRIN, 5'd0, 16'h0, 16'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Clear = 1'b1;
      Stop  = 1'b0;
      IR    = 32'h0;
      repeat (2) @(negedge Clock);

      // reset state
      check_out("reset", ST_RST, 15'h0, 5'd0, 16'h0, 16'h0);
      check("reset.illegal", 32'(Illegal), 32'd0);
      check("reset.count", InstrCount, 32'd0);
      Clear = 1'b0;
      @(negedge Clock);

      // mul R6,R7
      IR = IR_MUL;
      fetch("mul");
      step("mul.t3", ST_T3, S_YIN, 5'd0, 16'h0, 16'h0040);
      step("mul.t4", ST_T4, S_ZLOWIN | S_ZHIGHIN, ALU_MUL, 16'h0, 16'h0080);
      step("mul.t5", ST_T5, S_ZLOWOUT | S_LOIN, 5'd0, 16'h0, 16'h0);
      step("mul.t6", ST_T6, S_ZHIGHOUT | S_HIIN, 5'd0, 16'h0, 16'h0);

      // add R2,R3,R4: six cycles from T0 to the next T0
      IR = IR_ADD;
      fetch("add");
      step("add.t3", ST_T3, S_YIN, 5'd0, 16'h0, 16'h0008);
      step("add.t4", ST_T4, S_ZLOWIN | S_ZHIGHIN, ALU_ADD, 16'h0, 16'h0010);
      step("add.t5", ST_T5, S_ZLOWOUT, 5'd0, 16'h0004, 16'h0);

      // neg R5,R1
      IR = IR_NEG;
      fetch("neg");
      step("neg.t3", ST_T3, S_ZLOWIN | S_ZHIGHIN, ALU_NEG, 16'h0, 16'h0002);
      step("neg.t4", ST_T4, S_ZLOWOUT, 5'd0, 16'h0020, 16'h0);
      check("count.after3", InstrCount, exp_count(3));

      // Clear in T4 of mul aborts it
      IR = IR_MUL;
      fetch("abort");
      step("abort.t3", ST_T3, S_YIN, 5'd0, 16'h0, 16'h0040);
      check_out("abort.t4", ST_T4, S_ZLOWIN | S_ZHIGHIN, ALU_MUL, 16'h0, 16'h0080);
      Clear = 1'b1;
      @(negedge Clock);
      check_out("abort.rst", ST_RST, 15'h0, 5'd0, 16'h0, 16'h0);
      check("abort.count", InstrCount, 32'd0);
      check("abort.illegal", 32'(Illegal), 32'd0);
      Clear = 1'b0;
      @(negedge Clock);

      // undefined opcode halts with Illegal set
      IR = IR_ILL;
      fetch("ill");
      step("ill.t3", ST_T3, 15'h0, 5'd0, 16'h0, 16'h0);
      for (int i = 0; i < 10; i++) begin
         check_out("ill.halt", ST_HALT, 15'h0, 5'd0, 16'h0, 16'h0);
         check("ill.illegal", 32'(Illegal), 32'd1);
         @(negedge Clock);
      end
      Clear = 1'b1;
      @(negedge Clock);
      check_out("ill.rst", ST_RST, 15'h0, 5'd0, 16'h0, 16'h0);
      check("ill.cleared", 32'(Illegal), 32'd0);
      Clear = 1'b0;
      @(negedge Clock);

      // Stop raised in mul T5: T6 completes, then HALT
      IR = IR_MUL;
      fetch("stop");
      step("stop.t3", ST_T3, S_YIN, 5'd0, 16'h0, 16'h0040);
      step("stop.t4", ST_T4, S_ZLOWIN | S_ZHIGHIN, ALU_MUL, 16'h0, 16'h0080);
      check_out("stop.t5", ST_T5, S_ZLOWOUT | S_LOIN, 5'd0, 16'h0, 16'h0);
      Stop = 1'b1;
      @(negedge Clock);
      step("stop.t6", ST_T6, S_ZHIGHOUT | S_HIIN, 5'd0, 16'h0, 16'h0);
      check("stop.count", InstrCount, exp_count(1));
      check("stop.illegal", 32'(Illegal), 32'd0);
      Stop = 1'b0;
      for (int i = 0; i < 3; i++)
         step("stop.halt", ST_HALT, 15'h0, 5'd0, 16'h0, 16'h0);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
